// File: rtl/adc_pipe_stage_gen_if.sv
// Bundle of sample/offset inputs and per-stage decision outputs of the
// 1.5-bit pipeline stage-code generator.
interface adc_pipe_stage_gen_if #(
    parameter int VIN_W  = 8,
    parameter int OFFS_W = 7
);
    // Sample and comparator-offset side
    logic signed [VIN_W-1:0]  vin_i;
    logic                     vin_valid_i;
    logic signed [OFFS_W-1:0] offs1_i;
    logic signed [OFFS_W-1:0] offs2_i;

    // Stage decision side
    logic [2:0]               d1_o;
    logic                     d1_valid_o;
    logic [2:0]               d2_o;
    logic                     d2_valid_o;
    logic                     d3_o;
    logic                     d3_valid_o;
    logic                     sat_o;

    // Producer of samples / consumer of decisions (test or system side)
    modport master (
        output vin_i, vin_valid_i, offs1_i, offs2_i,
        input  d1_o, d1_valid_o, d2_o, d2_valid_o, d3_o, d3_valid_o, sat_o
    );

    // The stage-code generator itself
    modport slave (
        input  vin_i, vin_valid_i, offs1_i, offs2_i,
        output d1_o, d1_valid_o, d2_o, d2_valid_o, d3_o, d3_valid_o, sat_o
    );
endinterface

// File: rtl/adc_pipe_stage_gen.sv
// Stage-code generator for a 3-stage 1.5-bit pipelined ADC model.
// Stages 1 and 2 make a three-way decision, emit a one-hot pin code and pass
// a saturated residue on; stage 3 is a single comparator on residue 2.
// With ALIGNED=1 the stage-1/2 codes are delayed so all three decisions for a
// sample leave in the same cycle.
module adc_pipe_stage_gen #(
    parameter int VIN_W   = 8,
    parameter int OFFS_W  = 7,
    parameter int ALIGNED = 0
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    adc_pipe_stage_gen_if.slave  bus
);
    // Residue arithmetic is done two bits wider than the sample so that
    // 2x +/- Vref cannot wrap before saturation.
    localparam int RW = VIN_W + 2;

    localparam logic signed [RW-1:0] VREF_W = RW'(1 << (VIN_W - 1));
    localparam logic signed [RW-1:0] THR_W  = RW'(1 << (VIN_W - 3));
    localparam logic signed [RW-1:0] VMAX   = RW'((1 << (VIN_W - 1)) - 1);
    localparam logic signed [RW-1:0] VMIN   = RW'(-(1 << (VIN_W - 1)));

    localparam logic [2:0] CODE_NONE = 3'b000;
    localparam logic [2:0] CODE_NEG  = 3'b010;
    localparam logic [2:0] CODE_ZERO = 3'b100;
    localparam logic [2:0] CODE_POS  = 3'b001;

    // Per-stage registered results, indexed by stage (0 = stage 1)
    logic [1:0][VIN_W-1:0] res_w;
    logic [1:0][2:0]       code_w;
    logic [1:0]            sat_w;
    logic [1:0]            vld_w;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stage
            logic signed [VIN_W-1:0]  x_in;
            logic signed [OFFS_W-1:0] offs_in;
            logic                     vld_in;
            logic                     sat_in;

            logic signed [RW-1:0]     x_ext;
            logic signed [RW-1:0]     o_ext;
            logic signed [RW-1:0]     thr_hi;
            logic signed [RW-1:0]     thr_lo;
            logic signed [RW-1:0]     res_full;

            logic [2:0]               code_d;
            logic signed [VIN_W-1:0]  res_d;
            logic                     sat_d;

            logic [2:0]               code_q;
            logic signed [VIN_W-1:0]  res_q;
            logic                     sat_q;
            logic                     vld_q;

            // Stage 1 works on the raw sample, stage 2 on the stage-1 residue;
            // each stage's offset is taken on the edge its input is taken.
            if (gi == 0) begin : g_first
                assign x_in    = bus.vin_i;
                assign offs_in = bus.offs1_i;
                assign vld_in  = bus.vin_valid_i;
                assign sat_in  = 1'b0;
            end else begin : g_next
                assign x_in    = res_w[gi-1];
                assign offs_in = bus.offs2_i;
                assign vld_in  = vld_w[gi-1];
                assign sat_in  = sat_w[gi-1];
            end

            // Sub-ADC decision and saturated residue for this stage
            always_comb begin
                x_ext    = RW'(x_in);
                o_ext    = RW'(offs_in);
                thr_hi   = THR_W + o_ext;
                thr_lo   = o_ext - THR_W;
                code_d   = CODE_ZERO;
                res_full = x_ext + x_ext;
                if (x_ext >= thr_hi) begin
                    code_d   = CODE_POS;
                    res_full = x_ext + x_ext - VREF_W;
                end else if (x_ext < thr_lo) begin
                    code_d   = CODE_NEG;
                    res_full = x_ext + x_ext + VREF_W;
                end
                res_d = res_full[VIN_W-1:0];
                sat_d = sat_in;
                if (res_full > VMAX) begin
                    res_d = VMAX[VIN_W-1:0];
                    sat_d = 1'b1;
                end else if (res_full < VMIN) begin
                    res_d = VMIN[VIN_W-1:0];
                    sat_d = 1'b1;
                end
            end

            // Stage register: valid follows every cycle, data only loads on a
            // valid sample so bubbles leave the last decision visible.
            always_ff @(posedge clock_i or negedge reset_i) begin
                if (!reset_i) begin
                    vld_q  <= 1'b0;
                    code_q <= CODE_NONE;
                    res_q  <= '0;
                    sat_q  <= 1'b0;
                end else begin
                    vld_q <= vld_in;
                    if (vld_in) begin
                        code_q <= code_d;
                        res_q  <= res_d;
                        sat_q  <= sat_d;
                    end
                end
            end

            assign res_w[gi]  = res_q;
            assign code_w[gi] = code_q;
            assign sat_w[gi]  = sat_q;
            assign vld_w[gi]  = vld_q;
        end
    endgenerate

    // Stage 3: final comparator bit and the sample's accumulated saturation
    logic d3_q;
    logic sat3_q;
    logic vld3_q;

    // Comparator on residue 2 (>= 0 is just the sign bit clear)
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            vld3_q <= 1'b0;
            d3_q   <= 1'b0;
            sat3_q <= 1'b0;
        end else begin
            vld3_q <= vld_w[1];
            if (vld_w[1]) begin
                d3_q   <= ~res_w[1][VIN_W-1];
                sat3_q <= sat_w[1];
            end
        end
    end

    assign bus.d3_o       = d3_q;
    assign bus.d3_valid_o = vld3_q;
    assign bus.sat_o      = sat3_q;

    generate
        if (ALIGNED != 0) begin : g_aligned
            logic [2:0] d1_a_q;
            logic [2:0] d1_b_q;
            logic       v1_a_q;
            logic       v1_b_q;
            logic [2:0] d2_a_q;
            logic       v2_a_q;

            // Delay stage-1 codes by two and stage-2 codes by one cycle so
            // they line up with the stage-3 bit of the same sample.
            always_ff @(posedge clock_i or negedge reset_i) begin
                if (!reset_i) begin
                    v1_a_q <= 1'b0;
                    v1_b_q <= 1'b0;
                    v2_a_q <= 1'b0;
                    d1_a_q <= CODE_NONE;
                    d1_b_q <= CODE_NONE;
                    d2_a_q <= CODE_NONE;
                end else begin
                    v1_a_q <= vld_w[0];
                    v1_b_q <= v1_a_q;
                    v2_a_q <= vld_w[1];
                    if (vld_w[0]) begin
                        d1_a_q <= code_w[0];
                    end
                    if (v1_a_q) begin
                        d1_b_q <= d1_a_q;
                    end
                    if (vld_w[1]) begin
                        d2_a_q <= code_w[1];
                    end
                end
            end

            assign bus.d1_o       = d1_b_q;
            assign bus.d1_valid_o = v1_b_q;
            assign bus.d2_o       = d2_a_q;
            assign bus.d2_valid_o = v2_a_q;
        end else begin : g_skewed
            assign bus.d1_o       = code_w[0];
            assign bus.d1_valid_o = vld_w[0];
            assign bus.d2_o       = code_w[1];
            assign bus.d2_valid_o = vld_w[1];
        end
    endgenerate
endmodule

// File: tb/tb_adc_pipe_stage_gen.sv
// Bench for the stage-code generator: one skewed and one aligned instance
// share the same stimulus; expected decisions are queued when a sample is
// issued and popped by per-instance monitors when the outputs go valid.
module tb_adc_pipe_stage_gen;
    localparam int VIN_W  = 8;
    localparam int OFFS_W = 7;
    localparam int VREF   = 1 << (VIN_W - 1);
    localparam int THR    = VREF / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    adc_pipe_stage_gen_if #(.VIN_W(VIN_W), .OFFS_W(OFFS_W)) ifa ();
    adc_pipe_stage_gen_if #(.VIN_W(VIN_W), .OFFS_W(OFFS_W)) ifb ();

    adc_pipe_stage_gen #(.VIN_W(VIN_W), .OFFS_W(OFFS_W), .ALIGNED(0)) dut_a (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (ifa)
    );

    adc_pipe_stage_gen #(.VIN_W(VIN_W), .OFFS_W(OFFS_W), .ALIGNED(1)) dut_b (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (ifb)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int k;
        int c1;
        int c2;
        int d3;
        int sat;
    } exp_t;

    exp_t qa1[$];
    exp_t qa2[$];
    exp_t qa3[$];
    exp_t qb[$];

    // Reference: three-way decision against offset thresholds
    function automatic int decide(int x, int o);
        if (x >= THR + o) return 1;
        if (x < -THR + o) return -1;
        return 0;
    endfunction

    function automatic int pin_code(int d);
        if (d > 0) return 1;
        if (d < 0) return 2;
        return 4;
    endfunction

    function automatic int clamp_res(int r, inout int s);
        if (r > VREF - 1) begin s = 1; return VREF - 1; end
        if (r < -VREF)    begin s = 1; return -VREF;    end
        return r;
    endfunction

    task automatic expect_sample(int x, int o1, int o2, int k);
        exp_t e;
        int   s = 0;
        int   dd1, dd2, r1, r2;
        dd1   = decide(x, o1);
        r1    = clamp_res(2 * x - dd1 * VREF, s);
        dd2   = decide(r1, o2);
        r2    = clamp_res(2 * r1 - dd2 * VREF, s);
        e.k   = k;
        e.c1  = pin_code(dd1);
        e.c2  = pin_code(dd2);
        e.d3  = (r2 >= 0) ? 1 : 0;
        e.sat = s;
        qa1.push_back(e);
        qa2.push_back(e);
        qa3.push_back(e);
        qb.push_back(e);
    endtask

    // A sample's stage-2 offset is whatever is driven one cycle later, so the
    // expectation is completed on the following drive.
    bit pend_v  = 1'b0;
    int pend_x  = 0;
    int pend_o1 = 0;
    int pend_k  = 0;

    task automatic drive(bit v, int x, int o1, int o2);
        @(posedge clk);
        #1;
        ifa.vin_valid_i = v;   ifb.vin_valid_i = v;
        ifa.vin_i   = VIN_W'(x);  ifb.vin_i   = VIN_W'(x);
        ifa.offs1_i = OFFS_W'(o1); ifb.offs1_i = OFFS_W'(o1);
        ifa.offs2_i = OFFS_W'(o2); ifb.offs2_i = OFFS_W'(o2);
        if (pend_v) expect_sample(pend_x, pend_o1, o2, pend_k);
        pend_v  = v;
        pend_x  = x;
        pend_o1 = o1;
        pend_k  = cyc;
    endtask

    task automatic check_zero(string tag);
        check({tag, "_a_d1"},  int'(ifa.d1_o), 0);
        check({tag, "_a_v1"},  int'(ifa.d1_valid_o), 0);
        check({tag, "_a_d2"},  int'(ifa.d2_o), 0);
        check({tag, "_a_v2"},  int'(ifa.d2_valid_o), 0);
        check({tag, "_a_d3"},  int'(ifa.d3_o), 0);
        check({tag, "_a_v3"},  int'(ifa.d3_valid_o), 0);
        check({tag, "_a_sat"}, int'(ifa.sat_o), 0);
        check({tag, "_b_d1"},  int'(ifb.d1_o), 0);
        check({tag, "_b_v1"},  int'(ifb.d1_valid_o), 0);
        check({tag, "_b_d2"},  int'(ifb.d2_o), 0);
        check({tag, "_b_v2"},  int'(ifb.d2_valid_o), 0);
        check({tag, "_b_d3"},  int'(ifb.d3_o), 0);
        check({tag, "_b_v3"},  int'(ifb.d3_valid_o), 0);
        check({tag, "_b_sat"}, int'(ifb.sat_o), 0);
    endtask

    // Monitor for the skewed instance: each stage checked independently
    int la1 = 0, la2 = 0, la3 = 0;
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst_n) begin
            la1 = 0; la2 = 0; la3 = 0;
        end else begin
            if (ifa.d1_valid_o) begin
                if (qa1.size() == 0) check("a_d1_unexpected_valid", 1, 0);
                else begin
                    e = qa1.pop_front();
                    check("a_d1_latency", cyc, e.k + 1);
                    check("a_d1_code", int'(ifa.d1_o), e.c1);
                    la1 = e.c1;
                end
            end else check("a_d1_hold", int'(ifa.d1_o), la1);
            if (ifa.d2_valid_o) begin
                if (qa2.size() == 0) check("a_d2_unexpected_valid", 1, 0);
                else begin
                    e = qa2.pop_front();
                    check("a_d2_latency", cyc, e.k + 2);
                    check("a_d2_code", int'(ifa.d2_o), e.c2);
                    la2 = e.c2;
                end
            end else check("a_d2_hold", int'(ifa.d2_o), la2);
            if (ifa.d3_valid_o) begin
                if (qa3.size() == 0) check("a_d3_unexpected_valid", 1, 0);
                else begin
                    e = qa3.pop_front();
                    check("a_d3_latency", cyc, e.k + 3);
                    check("a_d3_bit", int'(ifa.d3_o), e.d3);
                    check("a_sat", int'(ifa.sat_o), e.sat);
                    la3 = e.d3;
                end
            end else check("a_d3_hold", int'(ifa.d3_o), la3);
        end
    end

    // Monitor for the aligned instance: all three valids move together
    int lb1 = 0, lb2 = 0, lb3 = 0;
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst_n) begin
            lb1 = 0; lb2 = 0; lb3 = 0;
        end else begin
            check("b_v1_aligned", int'(ifb.d1_valid_o), int'(ifb.d3_valid_o));
            check("b_v2_aligned", int'(ifb.d2_valid_o), int'(ifb.d3_valid_o));
            if (ifb.d3_valid_o) begin
                if (qb.size() == 0) check("b_unexpected_valid", 1, 0);
                else begin
                    e = qb.pop_front();
                    check("b_latency", cyc, e.k + 3);
                    check("b_d1_code", int'(ifb.d1_o), e.c1);
                    check("b_d2_code", int'(ifb.d2_o), e.c2);
                    check("b_d3_bit", int'(ifb.d3_o), e.d3);
                    check("b_sat", int'(ifb.sat_o), e.sat);
                    lb1 = e.c1; lb2 = e.c2; lb3 = e.d3;
                end
            end else begin
                check("b_d1_hold", int'(ifb.d1_o), lb1);
                check("b_d2_hold", int'(ifb.d2_o), lb2);
                check("b_d3_hold", int'(ifb.d3_o), lb3);
            end
        end
    end

    function automatic int rand_offs();
        if ($urandom_range(0, 1) == 0) return 0;
        return int'($urandom_range(0, 127)) - 64;
    endfunction

    task automatic random_cycles(int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 9) < 8, int'($urandom_range(0, 255)) - 128,
                  rand_offs(), rand_offs());
        end
    endtask

    initial begin
        int left;
        ifa.vin_valid_i = 1'b0; ifb.vin_valid_i = 1'b0;
        ifa.vin_i = '0;   ifb.vin_i = '0;
        ifa.offs1_i = '0; ifb.offs1_i = '0;
        ifa.offs2_i = '0; ifb.offs2_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Directed points: zero, large positive, full-scale negative,
        // threshold edges, saturating offset
        drive(1, 0, 0, 0);
        drive(1, 100, 0, 0);
        drive(1, -128, 0, 0);
        drive(1, 32, 0, 0);
        drive(1, 31, 0, 0);
        drive(1, 90, 63, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        // Back-to-back stream with one bubble
        drive(1, 0, 0, 0);
        drive(1, 100, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, -128, 0, 0);
        repeat (5) drive(0, 0, 0, 0);

        // Random stream with random offsets and bubbles
        random_cycles(400);
        repeat (5) drive(0, 0, 0, 0);

        // Reset with three samples in flight
        drive(1, 50, 0, 0);
        drive(1, -70, 0, 0);
        drive(1, 20, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        ifa.vin_valid_i = 1'b0; ifb.vin_valid_i = 1'b0;
        pend_v = 1'b0;
        qa1.delete(); qa2.delete(); qa3.delete(); qb.delete();
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) drive(0, 0, 0, 0);

        random_cycles(100);

        // Bounded drain of outstanding expectations
        left = 20;
        drive(0, 0, 0, 0);
        while (left > 0 && (qa1.size() + qa2.size() + qa3.size() + qb.size()) != 0) begin
            drive(0, 0, 0, 0);
            left--;
        end
        repeat (2) drive(0, 0, 0, 0);
        check("queues_drained", qa1.size() + qa2.size() + qa3.size() + qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
